instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Upstream feeder for the compute unit: accepts a program as 8-bit bytes from the chip input pins, packs them into 16-bit instruction words and stores them in a small local program buffer.
- On a start request, replays the stored program one instruction per cycle on the compute unit's instruction/enable inputs.
- Reports busy/done/overflow so the pin-level wrapper can sequence load and run phases.

Parameters:
- DEPTH, 8, number of 16-bit program words stored (power of two).
- ADDR_W, 3, log2(DEPTH); pointer width.
- HALT_OP, 4'hF, opcode value (bits [15:12]) that terminates a run early.

Ports:
- clk  input  1  system clock, rising-edge.
- rstn  input  1  asynchronous active-low reset; clears all state immediately.
- ena  input  1  global enable; when 0, all state and registered outputs hold.
- byte_in  input  8  program byte; high byte first, then low byte.
- byte_valid  input  1  byte_in valid this cycle.
- start  input  1  begin replay of stored program (level-sampled).
- clear  input  1  discard stored program (honoured in IDLE only).
- instruction  output  16  instruction word to compute unit (registered).
- en  output  1  instruction valid / compute enable (registered).
- busy  output  1  high in LOAD_LO, RUN and DONE.
- done  output  1  one-cycle pulse at end of run.
- overflow  output  1  sticky; a word was dropped because the buffer was full.
- count  output  ADDR_W+1  number of stored words, 0..DEPTH.

Behaviour:
- Reset (async): state=IDLE; instruction=0, en=0, done=0, overflow=0, count=0, wr_ptr=rd_ptr=0, hi_byte=0. Buffer contents need not be cleared.
- All transitions are on the rising clk edge with ena=1. With ena=0 nothing changes and en is forced to hold its last value.
- IDLE:
  - Priority: clear > start > byte_valid.
  - clear: count=0, wr_ptr=0, overflow=0; stays in IDLE.
  - start with count>0: go to RUN, rd_ptr=0.
  - start with count=0: go directly to DONE.
  - byte_valid: hi_byte=byte_in; go to LOAD_LO.
- LOAD_LO:
  - byte_valid with count<DEPTH: mem[wr_ptr]={hi_byte,byte_in}; wr_ptr++ (wraps at DEPTH); count++; go to IDLE.
  - byte_valid with count==DEPTH: word discarded, overflow=1, count unchanged; go to IDLE.
  - start and clear are ignored; the state waits indefinitely for the low byte.
- RUN, each cycle:
  - Read mem[rd_ptr].
  - If opcode==HALT_OP: en=0, instruction unchanged; go to DONE. The halt word is never forwarded.
  - Otherwise: instruction=word, en=1, rd_ptr++.
  - Leave for DONE after issuing word count-1.
  - byte_valid, start and clear are ignored.
- DONE: en=0, done=1 for exactly one cycle; rd_ptr=0; go to IDLE. The program is retained and can be re-run.
- Latency:
  - start sampled at edge k.
  - en=1 with word i visible after edge k+1+i, for i=0..N-1.
  - done visible after edge k+N+1.
  - No bubbles between words.
- en is 0 in every state other than RUN issue cycles. instruction holds its last value when en=0.
- Reset mid-run: en and done drop asynchronously; nothing further is issued.

Decomposition:
- Shared package: opcode constants (NOP=0, LOAD=1, ADD=2, SUB=3, AND=4, OR=5, NOT=6, XOR=7, HALT=F) and the state encoding (IDLE, LOAD_LO, RUN, DONE). The compute unit reuses the same opcode constants.
- One natural sub-module: seq_prog_mem, a DEPTH x 16 register array with one synchronous write port and a combinational read port, no reset.

Test Plan:
- Load bytes 12,05 / 13,03 / 20,12 then start -> after start edge, en=1 for exactly 3 cycles carrying 1205, 1303, 2012; done pulses on the next cycle; count stays 3.
- Load 9 words with DEPTH=8 -> count=8, overflow=1 after the 9th low byte; run issues only the first 8 words.
- Store 1205, F000, 2012 then start -> en=1 for 1205 only, then done=1; 2012 is never issued.
- start with count=0 -> done pulses 2 cycles after start; en never rises.
- Assert rstn=0 during the 2nd instruction of a 4-word run -> en=0 and count=0 immediately without a clock edge; after release, state is IDLE and start gives an immediate done.
- Hold ena=0 for 3 cycles mid-run, and separately assert start while in LOAD_LO -> output sequence is only delayed by 3 cycles, nothing dropped or duplicated; start in LOAD_LO has no effect.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the compute unit:
// opcode constants, sequencer state encoding and default sizing.
package instr_sequencer_pkg;

   localparam int WORD_W     = 16;
   localparam int BYTE_W     = 8;
   localparam int DEPTH_DEF  = 8;
   localparam int ADDR_W_DEF = 3;

   // Opcodes live in bits [15:12] of an instruction word.
   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LOAD = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_AND  = 4'h4,
      OP_OR   = 4'h5,
      OP_NOT  = 4'h6,
      OP_XOR  = 4'h7,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD_LO = 2'd1,
      ST_RUN     = 2'd2,
      ST_DONE    = 2'd3
   } seq_state_e;

   // Opcode field of an instruction word.
   function automatic logic [3:0] word_opcode(input logic [WORD_W-1:0] word);
      return word[WORD_W-1:WORD_W-4];
   endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program buffer: DEPTH x 16-bit register array, one synchronous write
// port and one combinational read port. Contents are not reset.
module seq_prog_mem
   import instr_sequencer_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   // Store one packed instruction word when the write strobe is high.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: packs incoming byte pairs into 16-bit words,
// buffers them, and replays the buffered program one word per cycle on
// instruction/en when started. A HALT word ends a run without being issued.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int          DEPTH   = DEPTH_DEF,
   parameter int          ADDR_W  = ADDR_W_DEF,
   parameter logic [3:0]  HALT_OP = OP_HALT
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              ena,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   input  logic              start,
   input  logic              clear,
   output logic [WORD_W-1:0] instruction,
   output logic              en,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   seq_state_e        state_q;
   logic [WORD_W-1:0] instruction_q;
   logic              en_q;
   logic              done_q;
   logic              overflow_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [BYTE_W-1:0] hi_byte_q;

   logic [WORD_W-1:0] rd_word_s;
   logic [WORD_W-1:0] mem_wdata_s;
   logic              mem_we_s;
   logic              buf_full_s;
   logic              last_word_s;
   logic              is_halt_s;

   seq_prog_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_prog_mem (
      .clk     (clk),
      .we_i    (mem_we_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (mem_wdata_s),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_word_s)
   );

   // Buffer status, run-termination flags and the program write strobe.
   always_comb begin
      buf_full_s  = (count_q == CNT_FULL);
      last_word_s = ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));
      is_halt_s   = (word_opcode(rd_word_s) == HALT_OP);
      mem_wdata_s = {hi_byte_q, byte_in};
      if (ena && (state_q == ST_LOAD_LO) && byte_valid && !buf_full_s) begin
         mem_we_s = 1'b1;
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Sequencer FSM with registered outputs; everything holds while ena is low.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         instruction_q <= {WORD_W{1'b0}};
         en_q          <= 1'b0;
         done_q        <= 1'b0;
         overflow_q    <= 1'b0;
         count_q       <= CNT_ZERO;
         wr_ptr_q      <= PTR_ZERO;
         rd_ptr_q      <= PTR_ZERO;
         hi_byte_q     <= {BYTE_W{1'b0}};
      end else if (ena) begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               en_q <= 1'b0;
               if (clear) begin
                  count_q    <= CNT_ZERO;
                  wr_ptr_q   <= PTR_ZERO;
                  overflow_q <= 1'b0;
               end else if (start) begin
                  rd_ptr_q <= PTR_ZERO;
                  state_q  <= (count_q != CNT_ZERO) ? ST_RUN : ST_DONE;
               end else if (byte_valid) begin
                  hi_byte_q <= byte_in;
                  state_q   <= ST_LOAD_LO;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LOAD_LO: begin
               // Waits for the low byte; start and clear have no effect here.
               en_q <= 1'b0;
               if (byte_valid) begin
                  if (buf_full_s) begin
                     overflow_q <= 1'b1;
                  end else begin
                     wr_ptr_q <= wr_ptr_q + PTR_ONE;
                     count_q  <= count_q + CNT_ONE;
                  end
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_LOAD_LO;
               end
            end
            ST_RUN: begin
               if (is_halt_s) begin
                  // HALT is consumed, never forwarded; instruction keeps its value.
                  en_q    <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  instruction_q <= rd_word_s;
                  en_q          <= 1'b1;
                  rd_ptr_q      <= rd_ptr_q + PTR_ONE;
                  state_q       <= last_word_s ? ST_DONE : ST_RUN;
               end
            end
            ST_DONE: begin
               en_q     <= 1'b0;
               done_q   <= 1'b1;
               rd_ptr_q <= PTR_ZERO;
               state_q  <= ST_IDLE;
            end
            default: begin
               en_q    <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end else begin
         state_q <= state_q;
      end
   end

   assign instruction = instruction_q;
   assign en          = en_q;
   assign done        = done_q;
   assign overflow    = overflow_q;
   assign count       = count_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random
// programs, checked against a queue-based model of the stored program.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ena;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        start;
   logic        clear;
   logic [15:0] instruction;
   logic        en;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;

   // Reference model: the stored program, the sticky overflow flag and the
   // last issued instruction.
   logic [15:0] prog[$];
   logic        ovf_m;
   logic [15:0] last_instr_m;

   instr_sequencer dut (
      .clk         (clk),
      .rstn        (rstn),
      .ena         (ena),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .start       (start),
      .clear       (clear),
      .instruction (instruction),
      .en          (en),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      prog.delete();
      ovf_m        = 1'b0;
      last_instr_m = 16'h0000;
   endtask

   task automatic send_word(input logic [15:0] w);
      byte_in    = w[15:8];
      byte_valid = 1'b1;
      cyc();
      chk("busy_load_lo", {31'd0, busy}, 32'd1);
      byte_in = w[7:0];
      cyc();
      byte_valid = 1'b0;
      if (prog.size() < 8) prog.push_back(w);
      else ovf_m = 1'b1;
      chk("count_after_load", {28'd0, count}, prog.size());
      chk("overflow_after_load", {31'd0, overflow}, {31'd0, ovf_m});
      chk("en_idle_after_load", {31'd0, en}, 32'd0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      prog.delete();
      ovf_m = 1'b0;
      chk("count_after_clear", {28'd0, count}, 32'd0);
      chk("overflow_after_clear", {31'd0, overflow}, 32'd0);
   endtask

   // Start a run and follow it cycle by cycle; stall_at >= 0 drops ena for
   // three cycles right after that word index is visible.
   task automatic run_prog(input int stall_at);
      logic [15:0] exp_q[$];
      bit          halted;
      for (int i = 0; i < prog.size(); i++) begin
         if (prog[i][15:12] == 4'hF) break;
         exp_q.push_back(prog[i]);
      end
      halted = (exp_q.size() < prog.size());
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("en_low_at_start", {31'd0, en}, 32'd0);
      chk("done_low_at_start", {31'd0, done}, 32'd0);
      for (int i = 0; i < exp_q.size(); i++) begin
         cyc();
         chk("run_en", {31'd0, en}, 32'd1);
         chk("run_instr", {16'd0, instruction}, {16'd0, exp_q[i]});
         chk("run_busy", {31'd0, busy}, 32'd1);
         chk("run_no_done", {31'd0, done}, 32'd0);
         last_instr_m = exp_q[i];
         if (i == stall_at) begin
            ena = 1'b0;
            for (int s = 0; s < 3; s++) begin
               cyc();
               chk("stall_en_hold", {31'd0, en}, 32'd1);
               chk("stall_instr_hold", {16'd0, instruction}, {16'd0, exp_q[i]});
               chk("stall_no_done", {31'd0, done}, 32'd0);
            end
            ena = 1'b1;
         end
      end
      if (halted) begin
         cyc();
         chk("halt_en_low", {31'd0, en}, 32'd0);
         chk("halt_no_done_yet", {31'd0, done}, 32'd0);
      end
      cyc();
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_en_low", {31'd0, en}, 32'd0);
      chk("done_instr_hold", {16'd0, instruction}, {16'd0, last_instr_m});
      cyc();
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("count_kept", {28'd0, count}, prog.size());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      rstn       = 1'b0;
      ena        = 1'b1;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      start      = 1'b0;
      clear      = 1'b0;
      model_reset();
      cyc();
      cyc();
      chk("rst_instr", {16'd0, instruction}, 32'd0);
      chk("rst_en", {31'd0, en}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_count", {28'd0, count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rstn = 1'b1;
      cyc();

      // Basic three-word program, then re-run the retained program.
      send_word(16'h1205);
      send_word(16'h1303);
      send_word(16'h2012);
      run_prog(-1);
      run_prog(-1);

      // Overflow: nine words into an eight-deep buffer.
      do_clear();
      for (int i = 0; i < 9; i++) send_word(16'h2100 + 16'(i));
      run_prog(-1);

      // HALT in the middle of the program.
      do_clear();
      send_word(16'h1205);
      send_word(16'hF000);
      send_word(16'h2012);
      run_prog(-1);

      // Empty program: immediate done.
      do_clear();
      run_prog(-1);

      // start while waiting for the low byte has no effect.
      byte_in    = 8'h45;
      byte_valid = 1'b1;
      cyc();
      byte_valid = 1'b0;
      start      = 1'b1;
      cyc();
      cyc();
      start = 1'b0;
      chk("ldlo_start_busy", {31'd0, busy}, 32'd1);
      chk("ldlo_start_en", {31'd0, en}, 32'd0);
      chk("ldlo_start_done", {31'd0, done}, 32'd0);
      chk("ldlo_start_count", {28'd0, count}, 32'd0);
      byte_in    = 8'h67;
      byte_valid = 1'b1;
      cyc();
      byte_valid = 1'b0;
      prog.push_back(16'h4567);
      chk("ldlo_count", {28'd0, count}, 32'd1);

      // ena held low for three cycles mid-run.
      send_word(16'h3111);
      send_word(16'h5222);
      send_word(16'h7333);
      run_prog(1);

      // Asynchronous reset during the second instruction of a run.
      do_clear();
      for (int i = 0; i < 4; i++) send_word(16'h6000 + 16'(i * 17));
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      chk("pre_rst_instr", {16'd0, instruction}, 32'h6011);
      #2 rstn = 1'b0;
      #1;
      chk("async_rst_en", {31'd0, en}, 32'd0);
      chk("async_rst_count", {28'd0, count}, 32'd0);
      chk("async_rst_done", {31'd0, done}, 32'd0);
      cyc();
      rstn = 1'b1;
      model_reset();
      cyc();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_en", {31'd0, en}, 32'd0);
      run_prog(-1);

      // Random programs, opcodes include occasional HALT and overflow.
      for (int r = 0; r < 8; r++) begin
         int n;
         do_clear();
         n = $urandom_range(0, 10);
         for (int i = 0; i < n; i++) begin
            w[15:12] = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            w[11:0]  = 12'($urandom);
            send_word(w);
         end
         run_prog((r % 2 == 1) ? int'($urandom_range(0, 2)) : -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
